// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if
//  Bundles the signals between the scan sequencer, its requester and the
//  4-to-1 mux it drives. clk and rst are plain module ports and are not
//  part of this interface.
//  Signals:
//   start       requester -> sequencer   scan request
//   continuous  requester -> sequencer   restart after each completed scan
//   ch_mask     requester -> sequencer   channel enables, bit i = mux input Ai
//   f_in        mux       -> sequencer   mux output F
//   s1, s0      sequencer -> mux         mux select lines
//   busy        sequencer -> requester   scan in progress (settle or done)
//   done        sequencer -> requester   one-cycle scan-complete pulse
//   data_out    sequencer -> requester   captured F value per channel
//   data_valid  sequencer -> requester   channel captured in the current scan
//  Modports:
//   master  the requester/mux environment side
//   slave   the sequencer side
interface mux_scan_sequencer_if;
  logic       start;
  logic       continuous;
  logic [3:0] ch_mask;
  logic       f_in;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       done;
  logic [3:0] data_out;
  logic [3:0] data_valid;

  modport master (
    output start, continuous, ch_mask, f_in,
    input  s1, s0, busy, done, data_out, data_valid
  );

  modport slave (
    input  start, continuous, ch_mask, f_in,
    output s1, s0, busy, done, data_out, data_valid
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//  Control stage for a 4-to-1 1-bit mux. Steps the select lines through the
//  enabled channels in ascending order. Each channel is held for SETTLE+1
//  cycles, then the mux output is captured into a 4-bit snapshot. A scan
//  runs once per start, or repeats back to back while continuous is high.
//  Parameters:
//   SETTLE  extra cycles the select is held before sampling f_in (0..15)
//   CNT_W   width of the settle counter; must hold SETTLE
//  Ports:
//   clk  single rising-edge clock
//   rst  synchronous, active-high reset
//   bus  slave side of mux_scan_sequencer_if (handshake, mask, mux I/O, results)
//  All outputs are registered.
module mux_scan_sequencer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux_scan_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       dout_q, dout_d;
  logic [3:0]       dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             launch;
  logic [2:0]       first_pick;
  logic [2:0]       next_pick;

  // Returns {found, index} of the lowest set bit of mask at or above lo.
  // lo may be 4 when the current channel is 3, in which case nothing is found.
  function automatic logic [2:0] pick_channel(input logic [3:0] mask,
                                              input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

  // State and datapath registers; reset wins over everything and discards
  // any partial scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'b00;
      cnt_q    <= '0;
      mask_q   <= 4'b0000;
      dout_q   <= 4'b0000;
      dvalid_q <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic. A fresh start from IDLE and a
  // continuous restart from DONE share one launch path, so both behave
  // identically, including the empty-mask shortcut straight to DONE.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    dout_d     = dout_q;
    dvalid_d   = dvalid_q;
    launch     = 1'b0;
    first_pick = pick_channel(bus.ch_mask, 3'd0);
    next_pick  = pick_channel(mask_q, {1'b0, sel_q} + 3'd1);

    case (state_q)
      ST_IDLE: begin
        launch = bus.start;
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          dout_d[sel_q]   = bus.f_in;
          dvalid_d[sel_q] = 1'b1;
          // Disabled channels are skipped by jumping directly to the next
          // enabled one, so they cost no cycles.
          if (next_pick[2]) begin
            sel_d = next_pick[1:0];
            cnt_d = CNT_W'(SETTLE);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.continuous) begin
          launch = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      if (bus.ch_mask != 4'b0000) begin
        mask_d   = bus.ch_mask;
        dvalid_d = 4'b0000;
        sel_d    = first_pick[1:0];
        cnt_d    = CNT_W'(SETTLE);
        state_d  = ST_SETTLE;
      end else begin
        state_d  = ST_DONE;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign bus.s1         = sel_q[1];
  assign bus.s0         = sel_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_out   = dout_q;
  assign bus.data_valid = dvalid_q;

endmodule
